// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage load/store sequencing against a fixed-latency RAM, OUT FIFO and halt tracking.
module mem_stage_ctrl #(
  parameter int ADDR_W = 12,
  parameter int READ_LAT = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              main_mem_read,
  input  logic              main_mem_write,
  input  logic [15:0]       mem_addr,
  input  logic [15:0]       mem_wdata,
  input  logic              out_en,
  input  logic              is_halt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [15:0]       ram_rdata,
  output logic [15:0]       mem_rdata,
  output logic              stall_mem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_dat,
  output logic              halted
);
  localparam int PW = $clog2(OUT_DEPTH);
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_LAST} state_t;
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [15:0] fifo [OUT_DEPTH];
  logic [15:0] hold;
  logic idle, issue, full_block, halt_wait, push, pop;
  assign idle = state == IDLE;
  assign issue = idle && main_mem_read && !main_mem_write;
  assign full_block = idle && out_en && count == (PW+1)'(OUT_DEPTH);
  assign halt_wait = idle && is_halt && count != '0;
  assign push = idle && out_en && !full_block;
  assign pop = out_valid && out_ready;
  assign ram_addr = mem_addr[ADDR_W-1:0];
  assign ram_wdata = mem_wdata;
  assign ram_we = !reset && idle && main_mem_write;
  assign ram_re = !reset && issue;
  assign stall_mem = issue || state == RD_WAIT || full_block || halt_wait;
  assign mem_rdata = state == RD_LAST ? ram_rdata : hold;
  assign out_valid = count != '0;
  assign out_dat = out_valid ? fifo[rd_ptr] : 16'h0;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (issue) begin
      cnt_nx = 3'(READ_LAT - 1);
      state_nx = READ_LAT == 1 ? RD_LAST : RD_WAIT;
    end else if (state == RD_WAIT) begin
      cnt_nx = cnt - 3'd1;
      state_nx = cnt == 3'd1 ? RD_LAST : RD_WAIT;
    end else if (state == RD_LAST) begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      hold <= '0;
      halted <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (state == RD_LAST) hold <= ram_rdata;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (is_halt && count == '0) halted <= 1'b1;
    end
  end
  // Storage needs no reset: out_dat is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= mem_wdata;
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed and randomized instruction stream checked against a queue/array model.
module tb_mem_stage_ctrl;
  localparam int AW = 12, RL = 2, OD = 4;
  localparam int NOP = 0, WR = 1, RD = 2, OUT = 3, HLT = 4, BOTH = 5;
  logic clk = 0, reset = 1;
  logic main_mem_read = 0, main_mem_write = 0, out_en = 0, is_halt = 0, out_ready = 0;
  logic [15:0] mem_addr = 0, mem_wdata = 0, ram_rdata, ram_wdata, mem_rdata, out_dat;
  logic [AW-1:0] ram_addr;
  logic ram_we, ram_re, stall_mem, out_valid, halted;
  logic [15:0] ram [1<<AW];
  logic [15:0] pipe [RL];
  logic [15:0] exp_mem [1<<AW];
  logic [15:0] q [$];
  logic [15:0] exp_hold;
  logic exp_halted, rnd_ready, st;
  int vecs = 0, errs = 0, kind = NOP, rd_age = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.ADDR_W(AW), .READ_LAT(RL), .OUT_DEPTH(OD)) dut (
    .clk(clk), .reset(reset), .main_mem_read(main_mem_read), .main_mem_write(main_mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .out_en(out_en), .is_halt(is_halt),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata), .mem_rdata(mem_rdata), .stall_mem(stall_mem),
    .out_valid(out_valid), .out_ready(out_ready), .out_dat(out_dat), .halted(halted)
  );

  // Synchronous RAM environment; data not from a read strobe is poisoned.
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    pipe[0] <= ram_re ? ram[ram_addr] : 16'hDEAD;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[RL-1];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int k, input logic [15:0] a, input logic [15:0] d);
    kind = k;
    main_mem_write = k == WR || k == BOTH;
    main_mem_read = k == RD || k == BOTH;
    out_en = k == OUT;
    is_halt = k == HLT;
    mem_addr = a;
    mem_wdata = d;
    rd_age = 0;
  endtask

  task automatic tick(output logic stalled);
    logic es;
    logic wr;
    @(negedge clk);
    wr = kind == WR || kind == BOTH;
    es = kind == RD ? rd_age < RL : kind == OUT ? q.size() == OD : kind == HLT ? q.size() != 0 : 1'b0;
    chk("stall", 16'(stall_mem), 16'(es));
    chk("ram_we", 16'(ram_we), 16'(wr));
    chk("ram_re", 16'(ram_re), 16'(kind == RD && rd_age == 0));
    if (wr || kind == RD) chk("ram_addr", 16'(ram_addr), 16'(mem_addr[AW-1:0]));
    if (wr) chk("ram_wdata", ram_wdata, mem_wdata);
    if (kind == RD && rd_age == RL) begin
      exp_hold = exp_mem[mem_addr[AW-1:0]];
      chk("load", mem_rdata, exp_hold);
    end else chk("rdata_hold", mem_rdata, exp_hold);
    chk("out_valid", 16'(out_valid), 16'(q.size() != 0));
    chk("out_dat", out_dat, q.size() != 0 ? q[0] : 16'h0);
    chk("halted", 16'(halted), 16'(exp_halted));
    @(posedge clk);
    if (wr) exp_mem[mem_addr[AW-1:0]] = mem_wdata;
    if (kind == HLT && q.size() == 0) exp_halted = 1;
    if (q.size() != 0 && out_ready) void'(q.pop_front());
    if (kind == OUT && !es) q.push_back(mem_wdata);
    if (kind == RD) rd_age++;
    stalled = es;
    #1;
  endtask

  task automatic issue(input int k, input logic [15:0] a, input logic [15:0] d);
    int n;
    logic s;
    n = 0;
    set_in(k, a, d);
    do begin
      if (rnd_ready) out_ready = 1'($urandom);
      tick(s);
      n++;
    end while (s && n < 40);
    chk("issue_done", 16'(s), 16'h0);
    if (k == RD) chk("load_latency", 16'(n - 1), 16'(RL));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = 16'h0;
      exp_mem[i] = 16'h0;
    end
    exp_hold = 0;
    exp_halted = 0;
    rnd_ready = 0;
    main_mem_read = 1;
    main_mem_write = 1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_we", 16'(ram_we), 16'h0);
    chk("reset_re", 16'(ram_re), 16'h0);
    @(posedge clk);
    #1;
    reset = 0;
    set_in(NOP, 0, 0);
    tick(st);
    // Store then load, and hold register afterwards
    issue(WR, 16'h0010, 16'hBEEF);
    issue(RD, 16'h0010, 16'h0);
    set_in(NOP, 0, 0);
    tick(st);
    // Upper address bits ignored
    issue(WR, 16'hF010, 16'h5A5A);
    issue(RD, 16'h0010, 16'h0);
    // Simultaneous read and write: write wins
    issue(BOTH, 16'h0030, 16'h7777);
    issue(RD, 16'h0030, 16'h0);
    issue(RD, 16'h0030, 16'h0);
    // FIFO fill, blocked fifth push, single pop, drain
    out_ready = 0;
    for (int i = 1; i <= 4; i++) issue(OUT, 16'h0, 16'(i));
    set_in(OUT, 16'h0, 16'd5);
    tick(st);
    out_ready = 1;
    tick(st);
    out_ready = 0;
    tick(st);
    chk("fifth_pushed", 16'(st), 16'h0);
    set_in(NOP, 0, 0);
    out_ready = 1;
    for (int i = 0; i < 5; i++) tick(st);
    // Halt waits for the FIFO to drain
    out_ready = 0;
    issue(OUT, 16'h0, 16'hA1);
    issue(OUT, 16'h0, 16'hA2);
    out_ready = 1;
    issue(HLT, 16'h0, 16'h0);
    chk("halt_drained", 16'(q.size()), 16'h0);
    set_in(NOP, 0, 0);
    for (int i = 0; i < 10; i++) tick(st);
    // Reset in the middle of a read with a queued entry
    out_ready = 0;
    issue(OUT, 16'h0, 16'h11);
    set_in(RD, 16'h0010, 16'h0);
    tick(st);
    reset = 1;
    @(negedge clk);
    chk("midrd_reset_re", 16'(ram_re), 16'h0);
    chk("midrd_reset_we", 16'(ram_we), 16'h0);
    @(posedge clk);
    #1;
    reset = 0;
    q.delete();
    exp_hold = 0;
    exp_halted = 0;
    set_in(NOP, 0, 0);
    for (int i = 0; i < 3; i++) tick(st);
    issue(RD, 16'h0010, 16'h0);
    // Randomized instruction stream
    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(0, 9);
      k = k < 2 ? NOP : k < 4 ? WR : k < 6 ? RD : k < 9 ? OUT : (k == 9 && i % 7 == 0) ? HLT : BOTH;
      issue(k, {4'($urandom), 8'h0, 4'($urandom)}, 16'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
